// File: rtl/tmds_pkg.sv
// Shared TMDS constants and helpers for the serializer slice.
package tmds_pkg;

  localparam int TMDS_WORD_W = 10;

  localparam logic [TMDS_WORD_W-1:0] CTRL_00 = 10'b1101010100;
  localparam logic [TMDS_WORD_W-1:0] CTRL_01 = 10'b0010101011;
  localparam logic [TMDS_WORD_W-1:0] CTRL_10 = 10'b0101010100;
  localparam logic [TMDS_WORD_W-1:0] CTRL_11 = 10'b1010101011;

  localparam logic [TMDS_WORD_W-1:0] TMDS_IDLE = CTRL_00;

  // Where the lane registers take their next word from on the current edge.
  typedef enum logic [1:0] {
    SRC_KEEP,
    SRC_HOLD,
    SRC_BYPASS,
    SRC_IDLE
  } load_src_e;

  function automatic int unsigned bit_index(input int unsigned cnt,
                                            input int unsigned word_w,
                                            input bit          lsb_first);
    return lsb_first ? cnt : (word_w - 1 - cnt);
  endfunction

endpackage

// File: rtl/tmds_serializer_mc_if.sv
// Parallel word handshake into the multi-lane serializer.
interface tmds_serializer_mc_if #(
  parameter int CHANNELS = 3,
  parameter int WORD_W   = 10
);
  logic [CHANNELS*WORD_W-1:0] in_data;
  logic                       in_valid;
  logic                       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/tmds_ser_lane.sv
// One serializer lane: current-word register plus the bit select onto the pad.
module tmds_ser_lane
  import tmds_pkg::*;
#(
  parameter int                WORD_W    = TMDS_WORD_W,
  parameter bit                LSB_FIRST = 1'b1,
  parameter logic [WORD_W-1:0] IDLE_WORD = TMDS_IDLE,
  localparam int               CNT_W     = $clog2(WORD_W)
) (
  input  logic              tmdsclk,
  input  logic              reset,
  input  logic              load,
  input  logic [WORD_W-1:0] load_word,
  input  logic [CNT_W-1:0]  cnt,
  output logic              serial
);

  logic [WORD_W-1:0] cur;
  logic [CNT_W-1:0]  idx;

  always_ff @(posedge tmdsclk) begin
    if (reset) begin
      cur <= IDLE_WORD;
    end else if (load) begin
      cur <= load_word;
    end
  end

  assign idx    = CNT_W'(bit_index(32'(cnt), WORD_W, LSB_FIRST));
  assign serial = cur[idx];

endmodule

// File: rtl/tmds_serializer_mc.sv
// Multi-lane N:1 serializer on tmdsclk: one-word holding buffer, lockstep lanes,
// idle-symbol insertion on underflow with a sticky flag.
module tmds_serializer_mc
  import tmds_pkg::*;
#(
  parameter int                CHANNELS  = 3,
  parameter int                WORD_W    = TMDS_WORD_W,
  parameter bit                LSB_FIRST = 1'b1,
  parameter logic [WORD_W-1:0] IDLE_WORD = TMDS_IDLE,
  localparam int               CNT_W     = $clog2(WORD_W)
) (
  input  logic                tmdsclk,
  input  logic                reset,
  tmds_serializer_mc_if.slave bus,
  input  logic                underflow_clr,
  output logic [CHANNELS-1:0] serial,
  output logic                word_start,
  output logic                underflow
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

  logic [CNT_W-1:0]           cnt;
  logic [CHANNELS*WORD_W-1:0] hold_data;
  logic [CHANNELS*WORD_W-1:0] load_data;
  logic                       hold_valid;
  logic                       armed;
  logic                       boundary;
  logic                       accept;
  load_src_e                  src;

  assign boundary     = (cnt == CNT_LAST);
  assign bus.in_ready = !hold_valid;
  assign accept       = bus.in_valid && !hold_valid;
  assign word_start   = (cnt == '0);

  // A full buffer always drains first; in_ready is low then, so no accept can race it.
  always_comb begin
    src       = SRC_KEEP;
    load_data = hold_data;
    if (boundary) begin
      if (hold_valid) begin
        src = SRC_HOLD;
      end else if (accept) begin
        src = SRC_BYPASS;
      end else begin
        src = SRC_IDLE;
      end
    end
    case (src)
      SRC_BYPASS: load_data = bus.in_data;
      SRC_IDLE:   load_data = {CHANNELS{IDLE_WORD}};
      default:    load_data = hold_data;
    endcase
  end

  always_ff @(posedge tmdsclk) begin
    if (reset) begin
      cnt        <= CNT_LAST;
      hold_valid <= 1'b0;
      armed      <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      cnt <= boundary ? '0 : cnt + CNT_W'(1);

      if (src == SRC_HOLD) begin
        hold_valid <= 1'b0;
      end else if (accept && !boundary) begin
        hold_valid <= 1'b1;
      end

      if (accept) begin
        armed <= 1'b1;
      end

      // A new underflow outranks a clear arriving on the same edge.
      if (src == SRC_IDLE && armed) begin
        underflow <= 1'b1;
      end else if (underflow_clr) begin
        underflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge tmdsclk) begin
    if (accept && !boundary) begin
      hold_data <= bus.in_data;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    tmds_ser_lane #(
      .WORD_W    (WORD_W),
      .LSB_FIRST (LSB_FIRST),
      .IDLE_WORD (IDLE_WORD)
    ) u_lane (
      .tmdsclk   (tmdsclk),
      .reset     (reset),
      .load      (src != SRC_KEEP),
      .load_word (load_data[c*WORD_W +: WORD_W]),
      .cnt       (cnt),
      .serial    (serial[c])
    );
  end

endmodule

// File: doc/tmds_serializer_mc.md
Name: tmds_serializer_mc

Overview:
- Parametrised multi-channel N:1 serializer. Runs entirely in the tmdsclk domain.
- Accepts one parallel word per channel through a valid/ready handshake and buffers one word. Shifts all channels out in lockstep, with a selectable bit order.
- On underflow it inserts a programmable idle symbol.
- Sits between the TMDS encoders (after their clock-domain crossing) and the output pads. Replaces the fixed 10:1 two-clock serializer.

Parameters:
- CHANNELS, 3, number of parallel lanes serialized in lockstep.
- WORD_W, 10, bits per word per lane.
- LSB_FIRST, 1, 1 = bit 0 is transmitted first; 0 = bit WORD_W-1 is transmitted first.
- IDLE_WORD, 10'b1101010100, symbol sent when no data is available (TMDS control 00).
- CNT_W, $clog2(WORD_W), localparam, width of the bit counter.

Ports:
- tmdsclk  in  1  bit clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- in_data  in  CHANNELS*WORD_W  lane c occupies bits [c*WORD_W +: WORD_W].
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a word this cycle.
- underflow_clr  in  1  clears the sticky underflow flag.
- serial  out  CHANNELS  serial bit per lane.
- word_start  out  1  high while the first bit of a word is on serial.
- underflow  out  1  sticky flag: an idle word was inserted after data had started.

Behaviour:
- State:
  - bit counter cnt (0..WORD_W-1).
  - Per-lane current-word register cur[c].
  - Holding buffer hold_data / hold_valid.
  - armed flag.
  - underflow flag.
- Reset (synchronous, while reset=1):
  - cnt=WORD_W-1, cur[c]=IDLE_WORD, hold_valid=0, armed=0, underflow=0.
  - Resulting outputs: in_ready=1, word_start=0, serial[c]=IDLE_WORD[WORD_W-1] if LSB_FIRST else IDLE_WORD[0].
- serial[c] = cur[c][idx], where idx = cnt if LSB_FIRST, else WORD_W-1-cnt. It is driven directly from registers, with no combinational path from the inputs.
- word_start = (cnt==0), registered-equivalent.
- Counter: increments each cycle and wraps from WORD_W-1 to 0.
- Boundary cycle (cnt==WORD_W-1): every cur[c] loads on the next edge, with source priority:
  1. hold_data, if hold_valid; hold_valid clears.
  2. in_data, if in_valid && in_ready (bypass; the word is accepted this cycle); armed sets.
  3. IDLE_WORD on all lanes; underflow sets if armed=1.
- in_ready = !hold_valid. It depends only on registers.
- Handshake outside the boundary cycle: in_valid && in_ready writes hold_data, sets hold_valid, and sets armed.
- In the boundary cycle with hold_valid=1: the hold drains, but in_ready is still 0 that cycle, so no simultaneous accept.
- Latency:
  - A word bypassed in a boundary cycle puts its first bit on serial the next cycle.
  - A buffered word waits for the next boundary.
- Throughput: at most one word per WORD_W cycles. in_ready deasserts while the buffer is full.
- Simultaneous underflow_clr and underflow set: set wins.
- underflow is cleared only by reset or underflow_clr.
- Idle words inserted before the first accepted word (armed=0) never flag underflow.
- Reset asserted mid-word: the word in flight and the buffered word are discarded; the block returns to the reset state on the next edge.
- in_data is not required to be stable after acceptance.

Decomposition:
- Package tmds_pkg:
  - TMDS_WORD_W=10.
  - Control symbols CTRL_00=10'b1101010100, CTRL_01=10'b0010101011, CTRL_10=10'b0101010100, CTRL_11=10'b1010101011.
  - Default idle = CTRL_00.
- Sub-module tmds_ser_lane: holds cur[c] and performs the bit select; instantiated CHANNELS times.
- The top level owns the counter, holding buffer, handshake, armed and underflow logic.

Test Plan:
- Reset, no input for 30 cycles:
  - serial[0] repeats IDLE_WORD LSB-first: 0,0,1,0,1,0,1,0,1,1.
  - word_start pulses every 10 cycles.
  - underflow stays 0.
- in_valid held with lane0=10'b0101110101, LSB_FIRST=1:
  - serial[0] emits 1,0,1,0,1,1,1,0,1,0 starting on the word_start cycle.
  - Back-to-back words continue with no idle gap.
- Same word with LSB_FIRST=0: emits 0,1,0,1,1,1,0,1,0,1.
- CHANNELS=3, lanes 10'h3FF / 10'h000 / 10'h155: lanes stay aligned bit-for-bit, and all lanes share the word_start cycle.
- One word sent, then in_valid=0:
  - The next boundary inserts IDLE_WORD and sets underflow=1.
  - underflow_clr pulse returns it to 0.
  - underflow_clr coincident with a new underflow leaves it at 1.
- Handshake boundaries:
  - Fill the buffer: in_ready=0 until the boundary drains it, then in_ready=1 one cycle later.
  - Assert reset at cnt=4: serial returns to the idle reset value next cycle, and hold_valid=0.
